// File: rtl/dense_engine_arbiter_if.sv
// Handshake bundle between the requesters / dense engine and the arbiter.
//   req         level request per requester
//   grant       one-hot grant, high from START through WAIT
//   sel         current or last winner, drives the engine input mux
//   eng_start   one-cycle start strobe to the engine
//   eng_done    engine completion pulse
//   req_done    one-cycle completion pulse to the winner
//   busy        arbiter not idle
//   timeout_err sticky watchdog flag
//   err_clr     synchronous clear of timeout_err
// The arbiter connects through the slave modport; the requester/engine side
// through the master modport.
interface dense_engine_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    sel;
  logic               eng_start;
  logic               eng_done;
  logic [NUM_REQ-1:0] req_done;
  logic               busy;
  logic               timeout_err;
  logic               err_clr;

  modport master (
    output req, eng_done, err_clr,
    input  grant, sel, eng_start, req_done, busy, timeout_err
  );

  modport slave (
    input  req, eng_done, err_clr,
    output grant, sel, eng_start, req_done, busy, timeout_err
  );
endinterface

// File: rtl/dense_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one dense-layer engine among
// NUM_REQ requesters, with a watchdog on every engine run.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    dense_engine_arbiter_if.slave (req/eng_done/err_clr in,
//          grant/sel/eng_start/req_done/busy/timeout_err out)
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for any req; picks first set bit at/after ptr
// S_START   | eng_start high for this cycle; watchdog cleared
// S_WAIT    | engine running; watchdog counts up each cycle
// S_RELEASE | grant low; ptr advances past the last winner
module dense_engine_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 16384
) (
  input logic                  clk,
  input logic                  rst_n,
  dense_engine_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW1   = ID_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RELEASE} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    pick;
  logic               pick_vld;
  logic [IW1-1:0]     sum;
  logic [IW1-1:0]     sel_inc;
  logic [ID_W-1:0]    ptr_next;

  // Rotate req so bit 0 is the requester at ptr; the lowest set bit of the
  // rotated vector is the winner. Scanning downward lets the lowest offset
  // overwrite any higher one.
  always_comb begin
    rot      = NUM_REQ'({bus.req, bus.req} >> ptr);
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + IW1'(i);
        if (sum >= IW1'(NUM_REQ)) sum = sum - IW1'(NUM_REQ);
        pick     = sum[ID_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_inc  = {1'b0, bus.sel} + IW1'(1);
    ptr_next = (sel_inc >= IW1'(NUM_REQ)) ? '0 : sel_inc[ID_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ptr             <= '0;
      cnt             <= '0;
      bus.grant       <= '0;
      bus.sel         <= '0;
      bus.eng_start   <= 1'b0;
      bus.req_done    <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.eng_start <= 1'b0;
      bus.req_done  <= '0;
      // A timeout set below overrides this clear on the same cycle.
      if (bus.err_clr) bus.timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            bus.grant     <= NUM_REQ'(1) << pick;
            bus.sel       <= pick;
            bus.eng_start <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // eng_done has priority over an expiry on the same cycle.
          if (bus.eng_done) begin
            bus.req_done <= NUM_REQ'(1) << bus.sel;
            bus.grant    <= '0;
            state        <= S_RELEASE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.grant       <= '0;
            state           <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          ptr      <= ptr_next;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_engine_arbiter.sv
// Self-checking bench for dense_engine_arbiter: a run-level reference model
// predicts every output each cycle, and directed phases pin the model with
// hand-computed grant orders, run lengths and flag values.
module tb_dense_engine_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int T  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dense_engine_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  dense_engine_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(T)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (run-level view) ----------------
  // m_run: a run owns the engine (start strobe cycle + waiting cycles)
  // m_age: cycles since the start strobe cycle (0 = strobe cycle)
  // m_rel: the single hand-back cycle after a run
  bit             m_run, m_rel, m_err, m_set;
  int             m_owner, m_age, m_last, m_ptr;
  logic [N-1:0]   m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_rel = 0; m_err = 0; m_owner = 0; m_age = 0;
      m_last = 0; m_ptr = 0; m_done = '0;
    end else begin
      m_done = '0;
      m_set  = 0;
      if (m_rel) begin
        m_rel = 0;
        m_ptr = (m_last + 1) % N;
      end else if (m_run) begin
        if (m_age == 0) m_age = 1;
        else if (bus.eng_done) begin
          m_done = N'(1) << m_owner; m_run = 0; m_rel = 1;
        end else if (m_age == T) begin
          m_set = 1; m_run = 0; m_rel = 1;
        end else m_age++;
      end else begin
        for (int off = 0; off < N; off++) begin
          if (!m_run && bus.req[(m_ptr + off) % N]) begin
            m_owner = (m_ptr + off) % N;
            m_last  = m_owner;
            m_run   = 1;
            m_age   = 0;
          end
        end
      end
      if (m_set) m_err = 1;
      else if (bus.err_clr) m_err = 0;
    end
  end

  // ---------------- compare + logging ----------------
  int           grant_q[$];
  logic [N-1:0] gvec_q[$];
  int           done_q[$];
  int           run_len_cur = 0;
  int           last_run_len = 0;

  always @(negedge clk) begin
    if (!rst_n) run_len_cur = 0;
    else begin
      chk("grant",     32'(bus.grant),     m_run ? (32'd1 << m_owner) : 32'd0);
      chk("sel",       32'(bus.sel),       32'(m_last));
      chk("eng_start", 32'(bus.eng_start), 32'(m_run && m_age == 0));
      chk("req_done",  32'(bus.req_done),  32'(m_done));
      chk("busy",      32'(bus.busy),      32'(m_run || m_rel));
      chk("timeout",   32'(bus.timeout_err), 32'(m_err));
      if (bus.eng_start) begin
        grant_q.push_back(int'(bus.sel));
        gvec_q.push_back(bus.grant);
      end
      for (int i = 0; i < N; i++) if (bus.req_done[i]) done_q.push_back(i);
      if (bus.grant != '0) run_len_cur++;
      else if (run_len_cur != 0) begin
        last_run_len = run_len_cur;
        run_len_cur  = 0;
      end
    end
  end

  // ---------------- engine stand-in ----------------
  int eng_mode = 0;   // 0: fixed latency, 1: random pulses
  int eng_lat  = -1;  // <=0: never completes
  int spur_cnt = 0;
  int spur_seen = 0;
  int cd = 0;

  always @(negedge clk) begin
    bus.eng_done = 1'b0;
    if (!rst_n) cd = 0;
    else if (eng_mode == 1) bus.eng_done = ($urandom_range(7) == 0);
    else begin
      if (spur_cnt != spur_seen) begin
        spur_seen    = spur_cnt;
        bus.eng_done = 1'b1;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.eng_done = 1'b1;
      end
      if (bus.eng_start && eng_lat > 0) cd = eng_lat;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_logs();
    grant_q.delete(); gvec_q.delete(); done_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_sel",   32'(bus.sel), 0);
    chk("rst_err",   32'(bus.timeout_err), 0);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (grant_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("grant_wait", 32'(grant_q.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(bus.busy), 0);
  endtask

  function automatic int qg(input int i);
    return (i < grant_q.size()) ? grant_q[i] : -1;
  endfunction

  function automatic int qd(input int i);
    return (i < done_q.size()) ? done_q[i] : -1;
  endfunction

  int rr_exp[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3};

  initial begin
    bus.req = '0; bus.err_clr = 1'b0;
    do_reset();

    // single requester, held: two back-to-back runs on requester 2
    clear_logs(); eng_lat = 12; bus.req = 4'b0100;
    wait_grants(2, 100);
    bus.req = '0;
    wait_idle();
    chk("single_g0", 32'(qg(0)), 2);
    chk("single_g1", 32'(qg(1)), 2);
    chk("single_gvec", 32'(gvec_q.size() > 0 ? gvec_q[0] : '0), 32'b0100);
    chk("single_d0", 32'(qd(0)), 2);
    chk("single_dn", 32'(done_q.size()), 2);
    chk("single_len", 32'(last_run_len), 13);

    // round robin then pointer wrap with 1001
    do_reset(); clear_logs(); eng_lat = 3; bus.req = 4'b1111;
    wait_grants(8, 400);
    bus.req = 4'b1001;
    wait_grants(10, 200);
    bus.req = '0;
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(qg(i)), 32'(rr_exp[i]));
      chk($sformatf("rr_done%0d", i),  32'(qd(i)), 32'(rr_exp[i]));
    end

    // watchdog
    clear_logs(); eng_lat = -1; bus.req = 4'b0010;
    wait_grants(1, 20);
    bus.req = '0;
    wait_idle();
    chk("wd_err", 32'(bus.timeout_err), 1);
    chk("wd_nodone", 32'(done_q.size()), 0);
    chk("wd_len", 32'(last_run_len), T + 1);
    @(negedge clk) bus.err_clr = 1'b1;
    @(negedge clk) bus.err_clr = 1'b0;
    chk("wd_clr", 32'(bus.timeout_err), 0);
    clear_logs(); eng_lat = 5; bus.req = 4'b0001;
    wait_grants(1, 20);
    bus.req = '0;
    wait_idle();
    chk("wd_next_g", 32'(qg(0)), 0);
    chk("wd_next_d", 32'(qd(0)), 0);

    // spurious eng_done in IDLE
    clear_logs();
    spur_cnt++;
    repeat (4) @(negedge clk);
    chk("spur_nodone", 32'(done_q.size()), 0);
    chk("spur_busy", 32'(bus.busy), 0);

    // req withdrawn during WAIT
    clear_logs(); eng_lat = 8; bus.req = 4'b0100;
    wait_grants(1, 20);
    repeat (2) @(negedge clk);
    bus.req = '0;
    wait_idle();
    chk("wdraw_done", 32'(qd(0)), 2);
    chk("wdraw_n", 32'(done_q.size()), 1);

    // eng_done on the watchdog expiry cycle
    clear_logs(); eng_lat = T; bus.req = 4'b1000;
    wait_grants(1, 20);
    bus.req = '0;
    wait_idle();
    chk("coll_done", 32'(qd(0)), 3);
    chk("coll_err", 32'(bus.timeout_err), 0);
    chk("coll_len", 32'(last_run_len), T + 1);

    // asynchronous reset mid-run
    clear_logs(); eng_lat = -1; bus.req = 4'b0100;
    wait_grants(1, 20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.grant), 0);
    chk("arst_sel",   32'(bus.sel), 0);
    chk("arst_busy",  32'(bus.busy), 0);
    chk("arst_start", 32'(bus.eng_start), 0);
    chk("arst_done",  32'(bus.req_done), 0);
    bus.req = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs(); eng_lat = 4; bus.req = 4'b0001;
    wait_grants(1, 20);
    bus.req = '0;
    wait_idle();
    chk("arst_g", 32'(qg(0)), 0);
    chk("arst_gvec", 32'(gvec_q.size() > 0 ? gvec_q[0] : '0), 32'b0001);

    // randomized traffic against the model
    eng_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.req     = N'($urandom);
      bus.err_clr = ($urandom_range(15) == 0);
    end
    eng_mode = 0; eng_lat = -1;
    bus.req = '0; bus.err_clr = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
